// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests under a DEPTH-entry credit limit,
// buffers in-order responses with their PC, and presents the head to decode.
module fetch_unit #(
  parameter int unsigned         XLEN         = 32,
  parameter int unsigned         DEPTH        = 4,
  parameter logic [XLEN-1:0]     RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_adr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            branch_v_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            instr_v_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   occ_q, occ_d, out_q, out_d, drop_q, drop_d;
  logic [XLEN-1:0] fifo_pc_q  [DEPTH];
  logic [XLEN-1:0] fifo_ins_q [DEPTH];

  logic            issue, rsp, push, pop;
  logic [CW:0]     credit;
  logic [XLEN-1:0] tgt;
  logic            unused_tgt;

  assign tgt        = {branch_target_i[XLEN-1:2], 2'b00};
  assign unused_tgt = ^branch_target_i[1:0];

  assign credit     = {1'b0, out_q} + {1'b0, occ_q};
  assign imem_req_o = reset_n & ~branch_v_i & (credit < DEPTH_C);
  assign imem_adr_o = pc_q;
  assign issue      = imem_req_o & imem_gnt_i;

  // A response with nothing outstanding is out of protocol and ignored.
  assign rsp        = imem_rvalid_i & (out_q != '0);
  assign push       = rsp & ~branch_v_i & (drop_q == '0);

  assign instr_v_o  = (occ_q != '0) & ~branch_v_i;
  assign pop        = instr_v_o & instr_ready_i;
  assign instr_o    = (occ_q != '0) ? fifo_ins_q[rptr_q] : NOP;
  assign pc_o       = (occ_q != '0) ? fifo_pc_q[rptr_q]  : '0;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    out_d    = out_q + CW'(issue) - CW'(rsp);
    if (branch_v_i) begin
      // rsp_pc tracks the PC of the next kept response; everything in flight now is dropped.
      pc_d     = tgt;
      rsp_pc_d = tgt;
      wptr_d   = '0;
      rptr_d   = '0;
      occ_d    = '0;
      drop_d   = out_q - CW'(rsp);
    end else begin
      if (issue) pc_d = pc_q + XLEN'(4);
      if (rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        wptr_d   = wptr_q + AW'(1);
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (pop) rptr_d = rptr_q + AW'(1);
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q     <= RESET_VECTOR;
      rsp_pc_q <= RESET_VECTOR;
      wptr_q   <= '0;
      rptr_q   <= '0;
      occ_q    <= '0;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      occ_q    <= occ_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      fifo_pc_q[wptr_q]  <= rsp_pc_q;
      fifo_ins_q[wptr_q] <= imem_rdata_i;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset_n)
    !(imem_rvalid_i && (out_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model with variable latency,
// expected {pc, instr} stream in a scoreboard queue checked by a separate monitor.
module tb_fetch_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        imem_req_o;
  logic [31:0] imem_adr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        branch_v_i;
  logic [31:0] branch_target_i;
  logic        instr_v_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_o      (imem_req_o),
    .imem_adr_o      (imem_adr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .branch_v_i      (branch_v_i),
    .branch_target_i (branch_target_i),
    .instr_v_o       (instr_v_o),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .instr_ready_i   (instr_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  mreq_t       mq[$];     // requests the memory still owes a response for
  exp_t        exp_q[$];  // issued, not yet consumed, not flushed
  int          arrived;   // kept responses delivered and not yet consumed
  logic [31:0] next_fetch;
  int unsigned cyc;
  int          total;
  int          bad;
  int          acc_cnt;
  bit          force_br;
  logic [31:0] force_tgt;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C ^ (a << 7);
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) == 0) t = {28'hFFFF_FFF, t[3:0]};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n       = 1'b0;
    imem_gnt_i    = 1'b0;
    instr_ready_i = 1'b0;
    branch_v_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req",     32'(imem_req_o), 32'd0);
    chk("rst_instr_v", 32'(instr_v_o),  32'd0);
    chk("rst_instr",   instr_o,         NOP);
    chk("rst_pc",      pc_o,            32'd0);
    chk("rst_adr",     imem_adr_o,      RV);
    mq.delete();
    exp_q.delete();
    arrived    = 0;
    next_fetch = RV;
    reset_n    = 1'b1;
  endtask

  task automatic step(input int gp, input int rp, input int bp, input int llo, input int lhi);
    logic        exp_req;
    logic        do_issue;
    logic        do_acc;
    int unsigned stale;
    mreq_t       r;
    @(negedge clk);
    cyc++;
    imem_gnt_i    = ($urandom_range(0, 99) < gp);
    instr_ready_i = ($urandom_range(0, 99) < rp);
    if (force_br) begin
      branch_v_i      = 1'b1;
      branch_target_i = force_tgt;
      force_br        = 1'b0;
    end else begin
      branch_v_i      = ($urandom_range(0, 99) < bp);
      branch_target_i = pick_target();
    end
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memfn(mq[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    stale = 0;
    foreach (mq[i]) if (mq[i].stale) stale++;
    exp_req = !branch_v_i && ((exp_q.size() + stale) < DEPTH);
    chk("imem_req", 32'(imem_req_o), 32'(exp_req));
    chk("imem_adr", imem_adr_o, next_fetch);
    chk("instr_v",  32'(instr_v_o), 32'(arrived != 0 && !branch_v_i));
    if (arrived == 0) begin
      chk("empty_instr", instr_o, NOP);
      chk("empty_pc",    pc_o,    32'd0);
    end
    do_issue = imem_req_o & imem_gnt_i;
    do_acc   = instr_v_o & instr_ready_i;
    if (do_acc) acc_cnt++;
    if (imem_rvalid_i) begin
      r = mq.pop_front();
      if (!r.stale && !branch_v_i) arrived++;
    end
    if (branch_v_i) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      exp_q.delete();
      arrived    = 0;
      next_fetch = {branch_target_i[31:2], 2'b00};
    end else begin
      if (do_acc && arrived > 0) arrived--;
      if (do_issue) begin
        mq.push_back('{next_fetch, cyc + $urandom_range(lhi, llo), 1'b0});
        exp_q.push_back('{next_fetch, memfn(next_fetch)});
        next_fetch = next_fetch + 32'd4;
      end
    end
  endtask

  // Monitor: every accepted instruction must be the oldest outstanding expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && instr_v_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("spurious_instr_v", 32'(instr_v_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc",    pc_o,    e.pc);
          chk("out_instr", instr_o, e.ins);
        end
      end
    end
  end

  initial begin
    int a;
    total = 0; bad = 0; acc_cnt = 0; cyc = 0; arrived = 0;
    force_br = 1'b0; force_tgt = '0; next_fetch = RV;
    reset_n = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    branch_v_i = 1'b0; branch_target_i = '0; instr_ready_i = 1'b0;

    do_reset();
    repeat (10) step(100, 100, 0, 1, 1);
    a = acc_cnt;
    repeat (20) step(100, 100, 0, 1, 1);
    chk("throughput", 32'(acc_cnt - a), 32'd20);

    repeat (12) step(100, 0, 0, 1, 1);
    repeat (12) step(100, 100, 0, 1, 1);

    repeat (4) step(100, 100, 0, 3, 3);
    force_br = 1'b1; force_tgt = 32'h0000_0103;
    step(100, 100, 0, 3, 3);
    repeat (12) step(100, 100, 0, 3, 3);

    repeat (6) step(0, 100, 0, 1, 1);
    repeat (8) step(100, 100, 0, 1, 1);

    force_br = 1'b1; force_tgt = 32'hFFFF_FFF4;
    step(100, 100, 0, 1, 1);
    repeat (12) step(100, 100, 0, 1, 2);

    repeat (1500) step(70, 70, 4, 1, 4);
    do_reset();
    repeat (30) step(100, 100, 0, 1, 1);
    repeat (1500) step(40, 85, 3, 1, 5);

    chk("min_accepted", 32'(acc_cnt > 500), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
